// File: rtl/axo_csr_file_pkg.sv
// axo_csr_file_pkg: CSR addresses, field positions, op encodings and FSM states
package axo_csr_file_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

endpackage

// File: rtl/axo_csr_file_helper.sv
// axo_csr_file_helper: new CSR value for write/set/clear from old value and operand
// Ports: op_i funct3[1:0], old_i current CSR value, wdata_i operand, new_o result.
module axo_csr_file_helper
    import axo_csr_file_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] new_o
);

    always_comb new_o = op_i == CSR_OP_RW ? wdata_i :
                        op_i == CSR_OP_RS ? (old_i | wdata_i) : (old_i & ~wdata_i);

endmodule

// File: rtl/axo_csr_file.sv
// axo_csr_file: machine-mode CSR file with 64-bit counters, trap entry and mret
// Ports: req_* CSR request (accepted in IDLE), resp_* one-cycle response with old value,
//        retire/trap_*/mret core events, mtvec_out/mepc_out/mie_global live trap state.
module axo_csr_file
    import axo_csr_file_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] HARTID     = '0,
    parameter logic [XLEN-1:0] MISA_RESET = 32'h40001100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [11:0]     req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_rs1_zero,
    input  logic [1:0]      privilege,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    input  logic            retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic            mie_global
);

    state_e          state_q, state_d;
    logic [11:0]     addr_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] wdata_q;
    logic            rs1z_q;
    logic [1:0]      priv_q;
    logic            st_mie_q, st_mpie_q;
    logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mscratch_q, mcause_q, mtval_q;
    logic [63:0]     mcycle_q, minstret_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            resp_illegal_q;
    logic [XLEN-1:0] old_val, new_val;
    logic            impl, we, illegal, abort, commit;

    always_comb begin
        old_val = '0;
        impl    = 1'b1;
        case (addr_q)
            CSR_MSTATUS: begin
                old_val[MSTATUS_MIE]  = st_mie_q;
                old_val[MSTATUS_MPIE] = st_mpie_q;
                old_val[12:11]        = 2'b11;
            end
            CSR_MISA:                                        old_val = MISA_RESET;
            CSR_MIP, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: old_val = '0;
            CSR_MIE:                                         old_val = mie_q;
            CSR_MTVEC:                                       old_val = mtvec_q;
            CSR_MSCRATCH:                                    old_val = mscratch_q;
            CSR_MEPC:                                        old_val = mepc_q;
            CSR_MCAUSE:                                      old_val = mcause_q;
            CSR_MTVAL:                                       old_val = mtval_q;
            CSR_MCYCLE, CSR_CYCLE:                           old_val = mcycle_q[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:                         old_val = mcycle_q[63:32];
            CSR_MINSTRET, CSR_INSTRET:                       old_val = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:                     old_val = minstret_q[63:32];
            CSR_MHARTID:                                     old_val = HARTID;
            default:                                         impl = 1'b0;
        endcase
    end

    axo_csr_file_helper #(.XLEN(XLEN)) u_helper (
        .op_i    (f3_q[1:0]),
        .old_i   (old_val),
        .wdata_i (wdata_q),
        .new_o   (new_val)
    );

    // Set/clear forms with a zero operand are pure reads and may touch read-only CSRs.
    assign we      = f3_q[1:0] == CSR_OP_RW || !rs1z_q;
    assign illegal = f3_q == 3'b000 || f3_q == 3'b100 || !impl || addr_q[9:8] > priv_q ||
                     (addr_q[11:10] == 2'b11 && we);
    assign abort   = trap_valid || mret;
    assign commit  = state_q == ST_EXEC && !illegal && we && !abort;

    always_comb state_d = state_q == ST_IDLE ? (req_valid ? ST_EXEC : ST_IDLE) :
                          state_q == ST_EXEC ? (abort ? ST_IDLE : ST_RESP) : ST_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            f3_q           <= '0;
            wdata_q        <= '0;
            rs1z_q         <= 1'b0;
            priv_q         <= '0;
            st_mie_q       <= 1'b0;
            st_mpie_q      <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mepc_q         <= '0;
            mscratch_q     <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            resp_rdata_q   <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
                rs1z_q  <= req_rs1_zero;
                priv_q  <= privilege;
            end
            if (state_q == ST_EXEC && !abort) begin
                resp_rdata_q   <= illegal ? '0 : old_val;
                resp_illegal_q <= illegal;
            end
            if (trap_valid) begin
                mepc_q    <= {trap_epc[XLEN-1:1], 1'b0};
                mcause_q  <= trap_cause;
                mtval_q   <= trap_tval;
                st_mpie_q <= st_mie_q;
                st_mie_q  <= 1'b0;
            end else if (mret) begin
                st_mie_q  <= st_mpie_q;
                st_mpie_q <= 1'b1;
            end else if (commit) begin
                case (addr_q)
                    CSR_MSTATUS: begin
                        st_mie_q  <= new_val[MSTATUS_MIE];
                        st_mpie_q <= new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= new_val & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= {new_val[XLEN-1:2], 2'b00};
                    CSR_MSCRATCH: mscratch_q <= new_val;
                    CSR_MEPC:     mepc_q     <= {new_val[XLEN-1:1], 1'b0};
                    CSR_MCAUSE:   mcause_q   <= new_val;
                    CSR_MTVAL:    mtval_q    <= new_val;
                    default: ;
                endcase
            end
            // A write to either counter half replaces it and skips that cycle's increment.
            mcycle_q   <= commit && addr_q == CSR_MCYCLE    ? {mcycle_q[63:32], new_val} :
                          commit && addr_q == CSR_MCYCLEH   ? {new_val, mcycle_q[31:0]} :
                          mcycle_q + 64'd1;
            minstret_q <= commit && addr_q == CSR_MINSTRET  ? {minstret_q[63:32], new_val} :
                          commit && addr_q == CSR_MINSTRETH ? {new_val, minstret_q[31:0]} :
                          minstret_q + 64'(retire);
        end
    end

    assign req_ready    = state_q == ST_IDLE;
    assign resp_valid   = state_q == ST_RESP;
    assign resp_rdata   = resp_rdata_q;
    assign resp_illegal = resp_illegal_q;
    assign mtvec_out    = mtvec_q;
    assign mepc_out     = mepc_q;
    assign mie_global   = st_mie_q;

endmodule

// File: tb/tb_axo_csr_file.sv
// tb_axo_csr_file: directed and randomized checks of axo_csr_file against a CSR reference model
module tb_axo_csr_file;

    localparam logic [31:0] HART = 32'h0000_0005;
    localparam logic [31:0] MISA = 32'h4000_1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_rs1_zero;
    logic [11:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic [1:0]  privilege;
    logic        resp_valid, resp_illegal;
    logic [31:0] resp_rdata;
    logic        retire, trap_valid, mret, mie_global;
    logic [31:0] trap_cause, trap_epc, trap_tval, mtvec_out, mepc_out;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axo_csr_file #(.XLEN(32), .HARTID(HART), .MISA_RESET(MISA)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_wdata(req_wdata), .req_rs1_zero(req_rs1_zero),
        .privilege(privilege),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .retire(retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_epc(trap_epc), .trap_tval(trap_tval), .mret(mret),
        .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_global(mie_global)
    );

    // Reference model state
    bit          m_st_mie, m_st_mpie, ok;
    logic [31:0] m_mie_reg, m_mtvec, m_mepc, m_mscratch, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ret;
    bit          m_commit = 1'b0;
    logic [11:0] m_addr;
    logic [31:0] m_nv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                         12'hC02, 12'hC80, 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
    endfunction

    function automatic bit m_wr_att(input logic [2:0] f3, input bit rz);
        return (f3 == 3'b001 || f3 == 3'b101) || !rz;
    endfunction

    function automatic bit m_illegal(input logic [11:0] a, input logic [2:0] f3,
                                     input bit rz, input logic [1:0] pv);
        return f3 == 3'b000 || f3 == 3'b100 || !m_impl(a) || a[9:8] > pv ||
               (a[11:10] == 2'b11 && m_wr_att(f3, rz));
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (32'(m_st_mpie) * 128) + (32'(m_st_mie) * 8);
            12'h301: return MISA;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ret[31:0];
            12'hB82, 12'hC82: return m_ret[63:32];
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: begin m_st_mie = v[3]; m_st_mpie = v[7]; end
            12'h304: m_mie_reg = v & 32'h888;
            12'h305: m_mtvec = v & ~32'h3;
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & ~32'h1;
            12'h342: m_mcause = v;
            12'h343: m_mtval = v;
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_st_mie = 0; m_st_mpie = 0;
            m_mie_reg = 0; m_mtvec = 0; m_mepc = 0; m_mscratch = 0; m_mcause = 0; m_mtval = 0;
            m_cyc = 0; m_ret = 0;
        end else begin
            ok = m_commit && !trap_valid && !mret;
            if (ok && m_addr == 12'hB00) m_cyc[31:0] = m_nv;
            else if (ok && m_addr == 12'hB80) m_cyc[63:32] = m_nv;
            else m_cyc = m_cyc + 1;
            if (ok && m_addr == 12'hB02) m_ret[31:0] = m_nv;
            else if (ok && m_addr == 12'hB82) m_ret[63:32] = m_nv;
            else if (retire) m_ret = m_ret + 1;
            if (trap_valid) begin
                m_mepc = trap_epc & ~32'h1;
                m_mcause = trap_cause;
                m_mtval = trap_tval;
                m_st_mpie = m_st_mie;
                m_st_mie = 0;
            end else if (mret) begin
                m_st_mie = m_st_mpie;
                m_st_mpie = 1;
            end else if (ok) m_write(m_addr, m_nv);
        end
    end

    always @(negedge clk) retire = 1'($urandom);

    task automatic chk_trap_state();
        chk("mtvec_out", mtvec_out, m_mtvec);
        chk("mepc_out", mepc_out, m_mepc);
        chk("mie_global", {31'b0, mie_global}, {31'b0, m_st_mie});
    endtask

    // Entered and left at a falling edge with the DUT idle. abort: 0 none, 1 trap, 2 mret in EXEC.
    task automatic do_csr(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] wd,
                          input bit rz, input logic [1:0] pv, input int abort,
                          output logic [31:0] rd, output bit il);
        logic [31:0] old;
        bit ill;
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1; req_addr = a; req_funct3 = f3; req_wdata = wd; req_rs1_zero = rz;
        privilege = pv;
        @(posedge clk);
        @(negedge clk);
        chk("exec_no_resp", {31'b0, resp_valid}, 32'd0);
        chk("exec_busy", {31'b0, req_ready}, 32'd0);
        req_addr = 12'($urandom); req_funct3 = 3'($urandom); req_wdata = $urandom;
        req_rs1_zero = 1'($urandom);
        ill = m_illegal(a, f3, rz, pv);
        old = m_read(a);
        m_addr = a;
        m_nv = f3[1:0] == 2'b01 ? wd : f3[1:0] == 2'b10 ? (old | wd) : (old & ~wd);
        m_commit = !ill && m_wr_att(f3, rz);
        if (abort == 1) begin
            trap_valid = 1; trap_cause = $urandom; trap_epc = $urandom; trap_tval = $urandom;
        end else if (abort == 2) mret = 1;
        @(posedge clk);
        @(negedge clk);
        m_commit = 0; trap_valid = 0; mret = 0; req_valid = 0;
        rd = resp_rdata;
        il = resp_illegal;
        if (abort != 0) begin
            chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("abort_ready", {31'b0, req_ready}, 32'd1);
        end else begin
            chk("resp_valid", {31'b0, resp_valid}, 32'd1);
            chk($sformatf("rdata_%h", a), resp_rdata, ill ? 32'h0 : old);
            chk($sformatf("illegal_%h", a), {31'b0, resp_illegal}, {31'b0, ill});
            @(posedge clk);
            @(negedge clk);
            chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
        end
        chk_trap_state();
    endtask

    task automatic pulse_event(input bit is_trap, input logic [31:0] c, input logic [31:0] e,
                               input logic [31:0] t);
        if (is_trap) begin
            trap_valid = 1; trap_cause = c; trap_epc = e; trap_tval = t;
        end else mret = 1;
        @(posedge clk);
        @(negedge clk);
        trap_valid = 0; mret = 0;
        chk_trap_state();
    endtask

    logic [11:0] addrs [26] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF11,
                                12'hF12, 12'hF13, 12'hF14, 12'h000, 12'h345, 12'h7C0,
                                12'hB01, 12'h100};
    logic [1:0]  privs [3] = '{2'b00, 2'b01, 2'b11};

    initial begin
        logic [31:0] rd;
        bit          il;
        rst = 1; req_valid = 0; req_addr = 0; req_funct3 = 0; req_wdata = 0;
        req_rs1_zero = 0; privilege = 2'b11; trap_valid = 0; trap_cause = 0;
        trap_epc = 0; trap_tval = 0; mret = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_illegal", {31'b0, resp_illegal}, 32'd0);
        chk("rst_mtvec", mtvec_out, 32'h0);
        chk("rst_mepc", mepc_out, 32'h0);
        chk("rst_mie", {31'b0, mie_global}, 32'd0);
        rst = 0;

        do_csr(12'h301, 3'b010, 0, 1, 2'b11, 0, rd, il);
        chk("t1_misa", rd, 32'h40001100);
        do_csr(12'h301, 3'b001, 32'h1234, 0, 2'b11, 0, rd, il);
        do_csr(12'h301, 3'b010, 0, 1, 2'b11, 0, rd, il);
        chk("t1_misa_kept", rd, 32'h40001100);

        do_csr(12'h340, 3'b001, 32'hDEADBEEF, 0, 2'b11, 0, rd, il);
        chk("t2_old", rd, 32'h0);
        do_csr(12'h340, 3'b010, 0, 1, 2'b11, 0, rd, il);
        chk("t2_mscratch", rd, 32'hDEADBEEF);

        do_csr(12'hF14, 3'b001, 32'h7, 0, 2'b11, 0, rd, il);
        chk("t3_ro_illegal", {31'b0, il}, 32'd1);
        chk("t3_ro_rdata", rd, 32'h0);
        do_csr(12'hF14, 3'b010, 0, 1, 2'b11, 0, rd, il);
        chk("t3_hartid", rd, HART);
        do_csr(12'h300, 3'b010, 0, 1, 2'b00, 0, rd, il);
        chk("t3_priv_illegal", {31'b0, il}, 32'd1);

        do_csr(12'hB80, 3'b001, 32'h0, 0, 2'b11, 0, rd, il);
        do_csr(12'hB00, 3'b001, 32'hFFFFFFFF, 0, 2'b11, 0, rd, il);
        do_csr(12'hB80, 3'b010, 0, 1, 2'b11, 0, rd, il);
        chk("t4_mcycleh_carry", rd, 32'h1);
        do_csr(12'hC00, 3'b010, 0, 1, 2'b00, 0, rd, il);
        chk("t4_cycle_user", {31'b0, il}, 32'd0);

        do_csr(12'h300, 3'b110, 32'h8, 0, 2'b11, 0, rd, il);
        chk("t5_mie_set", {31'b0, mie_global}, 32'd1);
        pulse_event(1, 32'h8000000B, 32'h1003, 32'h0);
        chk("t5_mepc", mepc_out, 32'h1002);
        chk("t5_mie_clr", {31'b0, mie_global}, 32'd0);
        do_csr(12'h300, 3'b010, 0, 1, 2'b11, 0, rd, il);
        chk("t5_mpie", rd, 32'h1880);
        pulse_event(0, 0, 0, 0);
        chk("t5_mret_mie", {31'b0, mie_global}, 32'd1);
        do_csr(12'h300, 3'b010, 0, 1, 2'b11, 0, rd, il);
        chk("t5_mstatus", rd, 32'h1888);

        do_csr(12'h340, 3'b001, 32'h1234, 0, 2'b11, 1, rd, il);
        do_csr(12'h340, 3'b010, 0, 1, 2'b11, 0, rd, il);
        chk("t6_mscratch_kept", rd, 32'hDEADBEEF);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] wd;
            bit          rz;
            int          ab;
            rz = ($urandom % 4) == 0;
            wd = rz ? 32'h0 : $urandom;
            ab = ($urandom % 10) == 0 ? int'($urandom_range(1, 2)) : 0;
            do_csr(addrs[$urandom % 26], 3'($urandom), wd, rz, privs[$urandom % 3], ab, rd, il);
            if (($urandom % 12) == 0) pulse_event(1'($urandom), $urandom, $urandom, $urandom);
            repeat ($urandom % 3) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
